// File: rtl/lab_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM state encoding and
// the digit limits used by the validity check and the reverse double-dabble correction.
package lab_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StConv = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VALUE  = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction for the reverse double-dabble: a digit that reads 8 or
// more after the right shift is reduced by 3.
module bcd_digit_adjust
    import lab_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // The correction only fires at >= 8, so the 4-bit subtraction cannot wrap.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= ADJ_THRESH) begin
            digit_o = digit_i - ADJ_VALUE;
        end
    end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one shift/correct iteration per cycle,
// start/done handshake, and an error flag for captured digits above 9.
module bcd_to_binary_seq
    import lab_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BW     = 10
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   BCD_in,
    output logic                  Busy,
    output logic                  Done,
    output logic [BW-1:0]         Bin_out,
    output logic                  Err
);

    localparam int unsigned DW   = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BW + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [BW-1:0]   bin_q, bin_d;
    logic [BW-1:0]   bin_out_q, bin_out_d;
    logic            err_q, err_d;

    logic [DW-1:0]   dig_sh;
    logic [DW-1:0]   dig_adj;
    logic [BW-1:0]   bin_sh;
    logic            bcd_invalid;
    logic            last_iter;

    // Digit 0 LSB falls into the binary register MSB.
    assign {dig_sh, bin_sh} = {dig_q, bin_q} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (dig_sh[4*g +: 4]),
            .digit_o (dig_adj[4*g +: 4])
        );
    end

    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (BCD_in[4*i +: 4] > DIGIT_MAX) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    assign last_iter = (cnt_q == CntW'(BW - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dig_d     = dig_q;
        bin_d     = bin_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    dig_d = BCD_in;
                    bin_d = '0;
                    cnt_d = '0;
                    err_d = bcd_invalid;
                    if (bcd_invalid) begin
                        bin_out_d = '0;
                        state_d   = StDone;
                    end else begin
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                dig_d = dig_adj;
                bin_d = bin_sh;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    bin_out_d = bin_sh;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            dig_q     <= '0;
            bin_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            bin_q     <= bin_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign Busy    = (state_q == StConv);
    assign Done    = (state_q == StDone);
    assign Bin_out = bin_out_q;
    assign Err     = err_q;

    // A correct conversion consumes every BCD weight, leaving no residue in the digits.
    residual_zero_a : assert property (
        @(posedge Clock) disable iff (!Resetn)
        (state_q == StConv && last_iter) |-> (dig_adj == '0)
    );

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: directed scenarios plus random
// BCD values compared against a plain decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;

    localparam int DIGITS = 3;
    localparam int BW     = 10;
    localparam int LAT    = BW + 1;

    logic              Clock;
    logic              Resetn;
    logic              Start;
    logic [4*DIGITS-1:0] BCD_in;
    logic              Busy;
    logic              Done;
    logic [BW-1:0]     Bin_out;
    logic              Err;

    int total;
    int bad;

    bcd_to_binary_seq #(
        .DIGITS (DIGITS),
        .BW     (BW)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Start   (Start),
        .BCD_in  (BCD_in),
        .Busy    (Busy),
        .Done    (Done),
        .Bin_out (Bin_out),
        .Err     (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: decimal weight sum; any nibble above 9 is an error with result 0.
    function automatic void ref_model(input logic [4*DIGITS-1:0] bcd, output int value,
                                      output bit invalid);
        int w;
        int d;
        value   = 0;
        invalid = 0;
        w       = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(bcd[4*i +: 4]);
            if (d > 9) invalid = 1;
            value = value + d * w;
            w     = w * 10;
        end
        if (invalid) value = 0;
    endfunction

    // Pulse Start for one cycle and wait (bounded) for Done; returns latency in
    // rising edges from Start assertion, Busy cycles seen, and Done in the next cycle.
    task automatic run_conv(input logic [4*DIGITS-1:0] bcd, output int lat, output int busy_cnt,
                            output logic done_after);
        @(negedge Clock);
        BCD_in = bcd;
        Start  = 1'b1;
        @(negedge Clock);
        Start    = 1'b0;
        BCD_in   = 12'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (!Done && lat < 40) begin
            if (Busy) busy_cnt++;
            @(negedge Clock);
            lat++;
        end
        @(negedge Clock);
        done_after = Done;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Start  = 1'($urandom);
            BCD_in = 12'($urandom);
            @(negedge Clock);
            total++;
            if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || Bin_out !== '0) begin
                bad++;
                $display("FAIL reset: busy=%b done=%b err=%b bin=%0d, required all 0",
                         Busy, Done, Err, Bin_out);
            end
        end
        Start  = 1'b0;
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic check_conv(input string name, input logic [4*DIGITS-1:0] bcd);
        int   lat, busy_cnt, exp_val;
        bit   exp_err;
        logic done_after;
        ref_model(bcd, exp_val, exp_err);
        run_conv(bcd, lat, busy_cnt, done_after);
        total++;
        if (lat !== (exp_err ? 1 : LAT)) begin
            bad++;
            $display("FAIL %s latency bcd=%h: got %0d required %0d", name, bcd, lat,
                     exp_err ? 1 : LAT);
        end
        total++;
        if (Bin_out !== BW'(exp_val) || Err !== exp_err) begin
            bad++;
            $display("FAIL %s result bcd=%h: got bin=%0d err=%b required bin=%0d err=%b",
                     name, bcd, Bin_out, Err, exp_val, exp_err);
        end
        total++;
        if (busy_cnt != (exp_err ? 0 : BW) || done_after !== 1'b0) begin
            bad++;
            $display("FAIL %s handshake bcd=%h: busy_cycles=%0d done_next=%b required %0d/0",
                     name, bcd, busy_cnt, done_after, exp_err ? 0 : BW);
        end
    endtask

    task automatic test_max();
        check_conv("max", 12'h999);
    endtask

    task automatic test_zero_pow2();
        check_conv("zero", 12'h000);
        check_conv("pow2", 12'h512);
        repeat (3) @(negedge Clock);
        total++;
        if (Bin_out !== 10'd512 || Done !== 1'b0) begin
            bad++;
            $display("FAIL hold: got bin=%0d done=%b required 512/0", Bin_out, Done);
        end
    endtask

    task automatic test_invalid();
        check_conv("invalid", 12'h1A3);
        check_conv("after_invalid", 12'h042);
    endtask

    task automatic test_busy_start();
        int done_cnt;
        done_cnt = 0;
        @(negedge Clock);
        BCD_in = 12'h123;
        Start  = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (3) begin
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        BCD_in = 12'h999;
        Start  = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        total++;
        if (Bin_out !== 10'd123 || done_cnt != 1) begin
            bad++;
            $display("FAIL busy_start: got bin=%0d dones=%0d required 123/1", Bin_out, done_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int done_cnt;
        done_cnt = 0;
        @(negedge Clock);
        BCD_in = 12'h777;
        Start  = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) begin
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        Resetn = 1'b0;
        #1;
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || Bin_out !== '0) begin
            bad++;
            $display("FAIL mid_reset outputs: busy=%b done=%b err=%b bin=%0d required 0",
                     Busy, Done, Err, Bin_out);
        end
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (Done) done_cnt++;
            @(negedge Clock);
        end
        total++;
        if (done_cnt != 0) begin
            bad++;
            $display("FAIL mid_reset done: got %0d pulses required 0", done_cnt);
        end
        check_conv("after_reset", 12'h250);
    endtask

    task automatic test_random();
        logic [4*DIGITS-1:0] bcd;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if ($urandom_range(0, 9) == 0) bcd[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           bcd[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            check_conv("random", bcd);
        end
    endtask

    task automatic test_back_to_back();
        check_conv("b2b_a", 12'h864);
        check_conv("b2b_b", 12'h001);
        check_conv("b2b_c", 12'h9F0);
        check_conv("b2b_d", 12'h100);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        Start  = 1'b0;
        BCD_in = '0;
        Resetn = 1'b0;
        test_reset();
        test_max();
        test_zero_pow2();
        test_invalid();
        test_busy_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_seq.md
# bcd_to_binary_seq

Sequential BCD-to-binary converter: takes a packed multi-digit BCD value (as produced for the decimal HEX displays) and recovers its binary magnitude using an iterative reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8). It sits between decimal-entry front ends (SW digits, BCD adder results) and binary datapath logic. It uses a start/done handshake and flags invalid BCD input.

## Interface
- DIGITS, default 3: number of BCD digits on the input.
- BW, default 10: binary result width. Must satisfy 2^BW > 10^DIGITS − 1. For DIGITS = 3, BW = 10.

- Clock  input  1: single clock; all state changes on the rising edge.
- Resetn  input  1: asynchronous, active-low reset.
- Start  input  1: request a conversion. Sampled only in IDLE.
- BCD_in  input  4*DIGITS: packed BCD value; digit 0 is in bits [3:0]. Captured on an accepted Start.
- Busy  output  1: high while in CONV.
- Done  output  1: high for exactly one cycle, in the DONE state.
- Bin_out  output  BW: result register. Holds its value until the next accepted Start.
- Err  output  1: set when any captured digit is > 9. Holds until the next accepted Start.

## Operation
- States: IDLE, CONV, DONE. Reset state is IDLE.
- **IDLE, Start = 1:** latch BCD_in into the digit shift register, clear the binary shift register, clear Err, clear the iteration counter.
  - If any digit is > 9: set Err, force Bin_out = 0, go to DONE. No conversion is performed.
  - Otherwise go to CONV.
- **IDLE, Start = 0:** stay in IDLE.
- **CONV:** one iteration per cycle.
  - Shift the concatenation {digits, bin} right by 1. Digit 0 LSB enters bin MSB.
  - Then, in every digit, if the digit is ≥ 8, subtract 3.
  - Increment the counter. After the BW-th iteration, copy bin to Bin_out and go to DONE.
- **DONE:** Done = 1 for one cycle, then unconditionally go to IDLE. Start is ignored in DONE.
- **Start while Busy:** ignored. BCD_in changes during CONV have no effect.
- **Arithmetic:** the per-digit correction is 4-bit unsigned. Corrected digits never underflow, because the correction applies only when the digit is ≥ 8.
- **Internal check:** after BW iterations the residual digit register must equal 0. This is internal only and has no port.

## Timing
- Reset values: Busy = 0, Done = 0, Err = 0, Bin_out = 0, state = IDLE, counter = 0.
- Resetn deasserted mid-conversion aborts immediately to reset values; no Done is produced.
- Cycle numbering: the edge that samples Start in IDLE is edge 0.
  - Valid input: Busy = 1 after edges 0 through BW−1 (cycles 1..BW). Bin_out is updated and Done = 1 after edge BW, for one cycle. Back in IDLE after edge BW+1.
  - Start-to-Done latency is BW+1 cycles; 11 for the defaults.
- Invalid input: Err = 1 and Done = 1 after edge 0, for one cycle. Busy never rises.
- Throughput: at most one conversion every BW+2 cycles. The earliest next Start is sampled in the IDLE cycle after DONE.
- Bin_out and Err change only on an accepted Start or at conversion completion.

## Structure
- Shared package (lab_pkg) holds:
  - the state encodings IDLE/CONV/DONE;
  - DIGIT_MAX = 9;
  - ADJ_THRESH = 8;
  - ADJ_VALUE = 3.
- One natural sub-module, **bcd_digit_adjust**: combinational; 4-bit digit in, corrected digit out (subtract 3 when ≥ 8). Instantiate it DIGITS times in a generate loop.
- The top level contains the FSM, the iteration counter (width clog2(BW+1)), the digit and binary shift registers, and the validity check.

## Test plan
- **Reset:** assert Resetn = 0 with random inputs → Busy = 0, Done = 0, Err = 0, Bin_out = 0.
- **Maximum value:** BCD_in = 12'h999, Start for 1 cycle → Done pulses exactly 11 cycles after Start, Bin_out = 10'd999 (10'h3E7), Err = 0.
- **Zero and power of two:**
  - BCD_in = 12'h000 → Bin_out = 0.
  - Then BCD_in = 12'h512 → Bin_out = 10'd512 (10'h200).
  - Each case gets exactly one Done pulse.
- **Invalid digit:** BCD_in = 12'h1A3 → Err = 1 and Done one cycle after Start, Bin_out = 0, Busy stays 0. A following valid 12'h042 → Err = 0, Bin_out = 42.
- **Start while busy:** start 12'h123, then pulse Start with 12'h999 at cycle 4 → Bin_out = 123, and only one Done.
- **Mid-conversion reset:** start 12'h777, assert Resetn = 0 at cycle 5 → all outputs 0 and no Done. After release, start 12'h250 → Bin_out = 250 with the normal 11-cycle latency.
